// File: rtl/pipe_control.sv
// Pipelined MIPS control: ID-stage decode, ID/EX -> EX/MEM -> MEM/WB control registers,
// load-use stall insertion, branch/jump squash, global freeze and saturating perf counters.
module pipe_control #(
  parameter int RA_W          = 5,
  parameter int CNT_W         = 16,
  parameter bit LOAD_STALL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       id_opcode,
  input  logic [5:0]       id_func,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             ex_branch_taken,
  input  logic             ext_stall,
  output logic             pc_stall,
  output logic             ifid_flush,
  output logic             id_jump,
  output logic             id_is_jr,
  output logic [1:0]       ex_alu_op,
  output logic             ex_alu_src,
  output logic             ex_reg_dst,
  output logic             ex_branch,
  output logic             ex_is_bne,
  output logic             ex_is_jal,
  output logic             ex_mem_read,
  output logic [RA_W-1:0]  ex_dest,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic             wb_reg_write,
  output logic             wb_mem_to_reg,
  output logic             wb_is_jal,
  output logic [RA_W-1:0]  wb_dest,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]      d_alu_op;
  logic            d_alu_src, d_reg_dst, d_branch, d_is_bne, d_is_jal;
  logic            d_mem_read, d_mem_write, d_reg_write, d_mem_to_reg;
  logic            d_valid, uses_rt;
  logic [RA_W-1:0] d_dest;

  // Registered-only stage controls that are not ports
  logic            ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic            mem_reg_write, mem_mem_to_reg, mem_is_jal;
  logic [RA_W-1:0] mem_dest;

  logic load_hz, do_stall, do_flush;

  always_comb begin
    d_alu_op     = 2'b00;
    d_alu_src    = 1'b0;
    d_reg_dst    = 1'b0;
    d_branch     = 1'b0;
    d_is_bne     = 1'b0;
    d_is_jal     = 1'b0;
    d_mem_read   = 1'b0;
    d_mem_write  = 1'b0;
    d_reg_write  = 1'b0;
    d_mem_to_reg = 1'b0;
    d_valid      = 1'b1;
    id_jump      = 1'b0;
    id_is_jr     = 1'b0;
    case (id_opcode)
      OP_R: begin
        d_reg_dst = 1'b1;
        d_alu_op  = 2'b10;
        if (id_func == FN_JR) begin
          id_jump  = 1'b1;
          id_is_jr = 1'b1;
        end else begin
          d_reg_write = 1'b1;
        end
      end
      OP_LW: begin
        d_alu_src    = 1'b1;
        d_mem_read   = 1'b1;
        d_mem_to_reg = 1'b1;
        d_reg_write  = 1'b1;
      end
      OP_SW: begin
        d_alu_src   = 1'b1;
        d_mem_write = 1'b1;
      end
      OP_BEQ: begin
        d_branch = 1'b1;
        d_alu_op = 2'b01;
      end
      OP_BNE: begin
        d_branch = 1'b1;
        d_is_bne = 1'b1;
        d_alu_op = 2'b01;
      end
      OP_ADDI: begin
        d_alu_src   = 1'b1;
        d_reg_write = 1'b1;
      end
      OP_ORI, OP_XORI: begin
        d_alu_src   = 1'b1;
        d_reg_write = 1'b1;
        d_alu_op    = 2'b11;
      end
      OP_J:    id_jump = 1'b1;
      OP_JAL: begin
        id_jump     = 1'b1;
        d_is_jal    = 1'b1;
        d_reg_write = 1'b1;
      end
      default: d_valid = 1'b0;
    endcase
  end

  // Undefined opcodes carry a zero destination so they are indistinguishable from a bubble
  assign d_dest  = !d_valid  ? '0 :
                   d_reg_dst ? id_rd :
                   d_is_jal  ? '1 : id_rt;
  assign uses_rt = (id_opcode == OP_R) || (id_opcode == OP_SW) ||
                   (id_opcode == OP_BEQ) || (id_opcode == OP_BNE);

  assign load_hz  = LOAD_STALL_EN && ex_mem_read && (ex_dest != '0) &&
                    ((ex_dest == id_rs) || (uses_rt && (ex_dest == id_rt)));
  assign do_stall = !ext_stall && !ex_branch_taken && load_hz;
  assign do_flush = !ext_stall && (ex_branch_taken || (id_jump && !load_hz));

  assign pc_stall   = !rst && (ext_stall || do_stall);
  assign ifid_flush = !rst && do_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_alu_op      <= 2'b00;
      ex_alu_src     <= 1'b0;
      ex_reg_dst     <= 1'b0;
      ex_branch      <= 1'b0;
      ex_is_bne      <= 1'b0;
      ex_is_jal      <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_mem_to_reg  <= 1'b0;
      ex_dest        <= '0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_is_jal     <= 1'b0;
      mem_dest       <= '0;
      wb_reg_write   <= 1'b0;
      wb_mem_to_reg  <= 1'b0;
      wb_is_jal      <= 1'b0;
      wb_dest        <= '0;
      stall_cnt      <= '0;
      flush_cnt      <= '0;
    end else if (!ext_stall) begin
      if (ex_branch_taken || load_hz) begin
        ex_alu_op     <= 2'b00;
        ex_alu_src    <= 1'b0;
        ex_reg_dst    <= 1'b0;
        ex_branch     <= 1'b0;
        ex_is_bne     <= 1'b0;
        ex_is_jal     <= 1'b0;
        ex_mem_read   <= 1'b0;
        ex_mem_write  <= 1'b0;
        ex_reg_write  <= 1'b0;
        ex_mem_to_reg <= 1'b0;
        ex_dest       <= '0;
      end else begin
        ex_alu_op     <= d_alu_op;
        ex_alu_src    <= d_alu_src;
        ex_reg_dst    <= d_reg_dst;
        ex_branch     <= d_branch;
        ex_is_bne     <= d_is_bne;
        ex_is_jal     <= d_is_jal;
        ex_mem_read   <= d_mem_read;
        ex_mem_write  <= d_mem_write;
        ex_reg_write  <= d_reg_write;
        ex_mem_to_reg <= d_mem_to_reg;
        ex_dest       <= d_dest;
      end
      mem_mem_read   <= ex_mem_read;
      mem_mem_write  <= ex_mem_write;
      mem_reg_write  <= ex_reg_write;
      mem_mem_to_reg <= ex_mem_to_reg;
      mem_is_jal     <= ex_is_jal;
      mem_dest       <= ex_dest;
      wb_reg_write   <= mem_reg_write;
      wb_mem_to_reg  <= mem_mem_to_reg;
      wb_is_jal      <= mem_is_jal;
      wb_dest        <= mem_dest;
      if (do_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
      if (do_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule
